alu_pwr_seq: RTL
================

Name: alu_pwr_seq

Overview:
- Power/isolation sequencer directly upstream of the ALU top level.
- Generates the ALU's alu_pwr_en and iso_en in a glitch-free order:
  - power-up: power on, settle, then release isolation;
  - power-down: drain, isolate, then power off.
- Gates the ALU start strobe so no operation launches while the domain is isolated or unpowered.
- Optional idle timer powers the ALU down automatically; it wakes on the next start request.

Parameters:
- PWR_UP_CYCLES, 4: cycles spent in PWR_UP with power on and isolation still asserted (min 1).
- ISO_CYCLES, 2: cycles spent in ISO_ON with isolation asserted and power still on (min 1).
- PD_CYCLES, 3: cycles spent in PWR_DN with power off before OFF is re-entered (min 1).
- IDLE_CYCLES, 8: consecutive idle cycles in ON that trigger auto-sleep; 0 disables auto-sleep.

Ports:
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous active-low reset.
- pwr_req, input, 1: level request; 1 = ALU wanted powered, 0 = power down.
- start_in, input, 1: start strobe from the issuing logic.
- busy, input, 1: ALU busy indication.
- start_out, output, 1: gated start strobe to the ALU.
- alu_pwr_en, output, 1: ALU domain power enable (registered).
- iso_en, output, 1: ALU output isolation enable (registered).
- ready, output, 1: 1 only in ON (registered).
- start_drop, output, 1: one-cycle pulse when start_in is refused.
- state, output, 3: current FSM state encoding.

Behaviour:
- Reset (async assert, sync release): state=OFF, alu_pwr_en=0, iso_en=1, ready=0, start_drop=0, counters=0, slept=0.
- Output values per state (alu_pwr_en / iso_en / ready):
  - OFF: 0 / 1 / 0
  - PWR_UP: 1 / 1 / 0
  - ON: 1 / 0 / 1
  - DRAIN: 1 / 0 / 0
  - ISO_ON: 1 / 1 / 0
  - PWR_DN: 0 / 1 / 0
- Outputs are registered; they change on the same edge as the state.
- Invariant: iso_en=0 only while alu_pwr_en=1. No cycle may show alu_pwr_en=0 with iso_en=0.
- OFF -> PWR_UP when pwr_req && (!slept || start_in).
  - The start_in that causes a wake is not forwarded; start_drop pulses.
- PWR_UP: down-counter loaded with PWR_UP_CYCLES-1 on entry; the state lasts exactly PWR_UP_CYCLES cycles.
  - Count reaches 0 -> ON.
  - pwr_req=0 at any point -> PWR_DN immediately; isolation was never released.
- ON:
  - start_out = start_in combinationally; zero latency.
  - pwr_req=0 -> DRAIN.
  - Idle timeout -> DRAIN and set slept=1.
- Idle counter:
  - Clears on start_in or busy; otherwise increments in ON, saturating.
  - Timeout fires when the count reaches IDLE_CYCLES-1 on an idle cycle.
  - Only counts in ON, and only when IDLE_CYCLES>0.
- DRAIN: start_in is refused. Stay while busy=1; busy=0 -> ISO_ON.
- ISO_ON: lasts exactly ISO_CYCLES cycles, then -> PWR_DN. pwr_req changes are ignored.
- PWR_DN: lasts exactly PWR_DN cycles, i.e. PD_CYCLES, then -> OFF. pwr_req reassertion is ignored until OFF.
  - No direct PWR_DN -> PWR_UP transition.
- slept clears on entering PWR_UP, or whenever pwr_req=0.
- start_drop=1 (registered, one cycle) for any start_in sampled outside ON.
- Simultaneous idle timeout and pwr_req=0 in ON: go to DRAIN; slept cleared next cycle because pwr_req=0.
- Simultaneous start_in and timeout in the same cycle: start_in wins. It is forwarded and the idle count clears.
- Counter width: $clog2 of the maximum parameter + 1.
- Unreachable state encodings recover to OFF with safe outputs.
- Reset mid-sequence (any state): outputs return asynchronously to 0 / 1 / 0 in the same cycle.

Decomposition:
- Shared package alu_pwr_pkg holds:
  - state typedef/localparams OFF=0, PWR_UP=1, ON=2, DRAIN=3, ISO_ON=4, PWR_DN=5;
  - the state width constant;
  - the safe output defaults.
- Natural sub-module: alu_pwr_timer.
  - Loadable down-counter with a done flag.
  - Shared by the PWR_UP, ISO_ON and PWR_DN waits.
  - The idle counter stays inline.

Test Plan:
- Power-up sequence:
  - Stimulus: reset, then pwr_req=1 sampled at edge 0.
  - Response: PWR_UP from edge 1 with pwr_en=1, iso=1. ON at edge 5 with iso=0, ready=1. iso never low before pwr_en high.
- Power-down with drain:
  - Stimulus: in ON, busy=1 for 3 cycles, pwr_req=0.
  - Response: DRAIN for 3 cycles, then ISO_ON for 2 cycles (iso=1, pwr_en=1), then PWR_DN for 3 cycles (pwr_en=0), then OFF.
- Start gating:
  - Stimulus: start_in pulses in PWR_UP, DRAIN and OFF.
  - Response: start_out=0 and start_drop=1 on the following cycle each time. In ON, start_out mirrors start_in in the same cycle.
- Auto-sleep and wake:
  - Stimulus: pwr_req=1, no start and no busy for 8 cycles in ON.
  - Response: DRAIN, then down to OFF. A later start_in starts PWR_UP with start_drop=1. ON again 4 cycles later.
- Aborts:
  - Case A stimulus: pwr_req drops at PWR_UP cycle 2. Response: PWR_DN next cycle, iso_en stays 1 throughout.
  - Case B stimulus: pwr_req reasserts during PWR_DN. Response: PWR_DN still completes to OFF, then PWR_UP.
- Async reset from ON:
  - Stimulus: rst_n=0 between edges.
  - Response: alu_pwr_en=0, iso_en=1, ready=0 immediately. state=OFF after release.

Source files
------------

// File: rtl/alu_pwr_pkg.sv
// Shared types and constants for the ALU power/isolation sequencer.
// State encoding, safe output defaults and counter sizing helper.
package alu_pwr_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        OFF    = 3'd0,
        PWR_UP = 3'd1,
        ON     = 3'd2,
        DRAIN  = 3'd3,
        ISO_ON = 3'd4,
        PWR_DN = 3'd5
    } state_t;

    typedef struct packed {
        logic pwr_en;
        logic iso_en;
        logic ready;
    } pwr_out_t;

    localparam pwr_out_t SAFE_OUT = '{
        pwr_en: 1'b0,
        iso_en: 1'b1,
        ready:  1'b0
    };

    // Output levels held in each state; anything illegal maps to safe.
    function automatic pwr_out_t state_out(input state_t s);
        pwr_out_t o;
        o = SAFE_OUT;
        case (s)
            PWR_UP:  o = '{pwr_en: 1'b1, iso_en: 1'b1, ready: 1'b0};
            ON:      o = '{pwr_en: 1'b1, iso_en: 1'b0, ready: 1'b1};
            DRAIN:   o = '{pwr_en: 1'b1, iso_en: 1'b0, ready: 1'b0};
            ISO_ON:  o = '{pwr_en: 1'b1, iso_en: 1'b1, ready: 1'b0};
            default: o = SAFE_OUT;
        endcase
        return o;
    endfunction

    // Counter width: clog2 of the largest timing parameter, plus one.
    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/alu_pwr_if.sv
// Handshake bundle between issuing logic and the ALU power sequencer.
// master = issuing side, slave = sequencer.
interface alu_pwr_if;
    import alu_pwr_pkg::*;

    logic               pwr_req;
    logic               start_in;
    logic               busy;
    logic               start_out;
    logic               alu_pwr_en;
    logic               iso_en;
    logic               ready;
    logic               start_drop;
    logic [STATE_W-1:0] state;

    modport master (
        output pwr_req,
        output start_in,
        output busy,
        input  start_out,
        input  alu_pwr_en,
        input  iso_en,
        input  ready,
        input  start_drop,
        input  state
    );

    modport slave (
        input  pwr_req,
        input  start_in,
        input  busy,
        output start_out,
        output alu_pwr_en,
        output iso_en,
        output ready,
        output start_drop,
        output state
    );

endinterface

// File: rtl/alu_pwr_timer.sv
// Loadable down-counter with a done flag for the timed sequencer waits.
// Loading value N gives N+1 cycles before done is seen.
module alu_pwr_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power/isolation sequencer in front of the ALU.
// Orders power and isolation glitch-free and gates the start strobe.
module alu_pwr_seq
    import alu_pwr_pkg::*;
#(
    parameter int PWR_UP_CYCLES = 4,
    parameter int ISO_CYCLES    = 2,
    parameter int PD_CYCLES     = 3,
    parameter int IDLE_CYCLES   = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_pwr_if.slave  bus
);

    localparam int CNT_W = cnt_width(
        PWR_UP_CYCLES, ISO_CYCLES, PD_CYCLES, IDLE_CYCLES
    );

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PU_LAST   = cnt_t'(PWR_UP_CYCLES - 1);
    localparam cnt_t ISO_LAST  = cnt_t'(ISO_CYCLES - 1);
    localparam cnt_t PD_LAST   = cnt_t'(PD_CYCLES - 1);
    localparam cnt_t IDLE_LAST =
        cnt_t'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam bit   IDLE_EN   = (IDLE_CYCLES > 0);

    state_t   state_q;
    state_t   state_d;
    pwr_out_t out_q;
    pwr_out_t out_d;
    logic     drop_q;
    logic     slept;
    cnt_t     idle_cnt;
    logic     idle_cyc;
    logic     idle_hit;
    logic     tmr_load;
    cnt_t     tmr_val;
    logic     tmr_done;

    alu_pwr_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign idle_cyc = !bus.start_in && !bus.busy;
    assign idle_hit = IDLE_EN && (state_q == ON)
                   && idle_cyc && (idle_cnt == IDLE_LAST);

    // Next state, timer reload on entry and next output levels.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            OFF: begin
                if (bus.pwr_req && (!slept || bus.start_in))
                    state_d = PWR_UP;
            end
            PWR_UP: begin
                if (!bus.pwr_req)
                    state_d = PWR_DN;
                else if (tmr_done)
                    state_d = ON;
            end
            ON: begin
                if (!bus.pwr_req || idle_hit)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (!bus.busy)
                    state_d = ISO_ON;
            end
            ISO_ON: begin
                if (tmr_done)
                    state_d = PWR_DN;
            end
            PWR_DN: begin
                if (tmr_done)
                    state_d = OFF;
            end
            default: state_d = OFF;
        endcase
        tmr_load = (state_d != state_q);
        case (state_d)
            PWR_UP:  tmr_val = PU_LAST;
            ISO_ON:  tmr_val = ISO_LAST;
            PWR_DN:  tmr_val = PD_LAST;
            default: tmr_val = '0;
        endcase
        out_d = state_out(state_d);
    end

    // State and outputs move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            out_q   <= SAFE_OUT;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            drop_q  <= bus.start_in && (state_q != ON);
        end
    end

    // Idle run length while ON; any activity or leaving ON clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!IDLE_EN || state_q != ON || !idle_cyc) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Auto-sleep marker: only a start request may wake from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slept <= 1'b0;
        end else if (!bus.pwr_req) begin
            slept <= 1'b0;
        end else if (state_q != PWR_UP && state_d == PWR_UP) begin
            slept <= 1'b0;
        end else if (idle_hit) begin
            slept <= 1'b1;
        end
    end

    assign bus.start_out  = bus.start_in && (state_q == ON);
    assign bus.alu_pwr_en = out_q.pwr_en;
    assign bus.iso_en     = out_q.iso_en;
    assign bus.ready      = out_q.ready;
    assign bus.start_drop = drop_q;
    assign bus.state      = state_q;

endmodule
